// File: rtl/sum_1digit_bcd_if.sv
// rtl/sum_1digit_bcd_if.sv - operand and result bundle for one BCD adder digit
interface sum_1digit_bcd_if;
   logic [3:0] nr1;
   logic [3:0] nr2;
   logic       carry_in;
   logic       in_valid;
   logic [3:0] sum;
   logic       carry_out;
   logic [3:0] sum_q;
   logic       carry_q;
   logic       out_valid;

   // Producer side: drives operands, observes results
   modport master (
      output nr1, nr2, carry_in, in_valid,
      input  sum, carry_out, sum_q, carry_q, out_valid
   );

   // Adder side: consumes operands, drives results
   modport slave (
      input  nr1, nr2, carry_in, in_valid,
      output sum, carry_out, sum_q, carry_q, out_valid
   );
endinterface

// File: rtl/sum_1digit_bcd.sv
// rtl/sum_1digit_bcd.sv - single-digit BCD adder, optional digit check via SUM_1DIGIT_BCD_DIGIT_CHECK_EN
module sum_1digit_bcd (
   input  logic            clk,
   input  logic            rst,
   sum_1digit_bcd_if.slave bus
`ifdef SUM_1DIGIT_BCD_DIGIT_CHECK_EN
   ,
   output logic            bcd_err,
   output logic            bcd_err_c
`endif
);

   logic [4:0] raw;
   logic [3:0] adj;
   logic       dec_carry;
   logic [3:0] sum_c;

   // Binary sum of the digit, then decimal correction when it passes 9.
   // Only the low nibble of raw + 6 survives, so the add is done at 4 bits.
   always_comb begin
      raw       = {1'b0, bus.nr1} + {1'b0, bus.nr2} + {4'd0, bus.carry_in};
      adj       = raw[3:0] + 4'd6;
      dec_carry = (raw > 5'd9);
      sum_c     = dec_carry ? adj : raw[3:0];
   end

   assign bus.sum       = sum_c;
   assign bus.carry_out = dec_carry;

`ifdef SUM_1DIGIT_BCD_DIGIT_CHECK_EN
   // Flag any operand outside the decimal digit range.
   always_comb begin
      bcd_err_c = (bus.nr1 > 4'd9) | (bus.nr2 > 4'd9);
   end
`endif

   // Registered result: captured on in_valid, held otherwise; reset wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.sum_q     <= 4'd0;
         bus.carry_q   <= 1'b0;
         bus.out_valid <= 1'b0;
`ifdef SUM_1DIGIT_BCD_DIGIT_CHECK_EN
         bcd_err       <= 1'b0;
`endif
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.sum_q   <= sum_c;
            bus.carry_q <= dec_carry;
`ifdef SUM_1DIGIT_BCD_DIGIT_CHECK_EN
            bcd_err     <= bcd_err_c;
`endif
         end
      end
   end

endmodule

// File: tb/tb_sum_1digit_bcd.sv
// tb/tb_sum_1digit_bcd.sv - directed self-checking bench for sum_1digit_bcd
module tb_sum_1digit_bcd;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   sum_1digit_bcd_if bus_lo ();
   sum_1digit_bcd_if bus_hi ();

   assign bus_hi.carry_in = bus_lo.carry_out;

`ifdef SUM_1DIGIT_BCD_DIGIT_CHECK_EN
   logic err_lo, err_lo_c, err_hi, err_hi_c;
   sum_1digit_bcd u_lo (.clk(clk), .rst(rst), .bus(bus_lo), .bcd_err(err_lo), .bcd_err_c(err_lo_c));
   sum_1digit_bcd u_hi (.clk(clk), .rst(rst), .bus(bus_hi), .bcd_err(err_hi), .bcd_err_c(err_hi_c));
`else
   sum_1digit_bcd u_lo (.clk(clk), .rst(rst), .bus(bus_lo));
   sum_1digit_bcd u_hi (.clk(clk), .rst(rst), .bus(bus_hi));
`endif

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic drive(input int a, input int b, input int c, input logic v);
      @(negedge clk);
      bus_lo.nr1      = 4'(a);
      bus_lo.nr2      = 4'(b);
      bus_lo.carry_in = 1'(c);
      bus_lo.in_valid = v;
      #1;
   endtask

   task automatic comb_check(input string tag, input int a, input int b, input int c,
                             input int exp_sum, input int exp_cy);
      drive(a, b, c, 1'b0);
      check({tag, "_sum"}, {4'd0, bus_lo.sum}, 8'(exp_sum));
      check({tag, "_cy"},  {7'd0, bus_lo.carry_out}, 8'(exp_cy));
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence
   initial begin
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      bus_lo.nr1 = 4'd0; bus_lo.nr2 = 4'd0; bus_lo.carry_in = 1'b0; bus_lo.in_valid = 1'b0;
      bus_hi.nr1 = 4'd0; bus_hi.nr2 = 4'd0; bus_hi.in_valid = 1'b0;
      after_edge();
      after_edge();
      check("rst_sum_q",     {4'd0, bus_lo.sum_q},     8'd0);
      check("rst_carry_q",   {7'd0, bus_lo.carry_q},   8'd0);
      check("rst_out_valid", {7'd0, bus_lo.out_valid}, 8'd0);

      @(negedge clk);
      rst = 1'b0;

      // 3 + 4: combinational then registered one edge later
      drive(3, 4, 0, 1'b1);
      check("c347_sum", {4'd0, bus_lo.sum},       8'd7);
      check("c347_cy",  {7'd0, bus_lo.carry_out}, 8'd0);
      after_edge();
      check("r347_sum_q",   {4'd0, bus_lo.sum_q},     8'd7);
      check("r347_carry_q", {7'd0, bus_lo.carry_q},   8'd0);
      check("r347_valid",   {7'd0, bus_lo.out_valid}, 8'd1);

      comb_check("c55",    5,  5, 0, 0, 1);
      comb_check("c991",   9,  9, 1, 9, 1);
      comb_check("c901",   9,  0, 1, 0, 1);
      comb_check("c900",   9,  0, 0, 9, 0);
      comb_check("c15151", 15, 15, 1, 5, 1);
      comb_check("c1200",  12, 0, 0, 2, 1);
      comb_check("c000",   0,  0, 0, 0, 0);

      // Capture then hold with in_valid low
      drive(9, 9, 1, 1'b1);
      after_edge();
      check("cap_sum_q",   {4'd0, bus_lo.sum_q},     8'd9);
      check("cap_carry_q", {7'd0, bus_lo.carry_q},   8'd1);
      check("cap_valid",   {7'd0, bus_lo.out_valid}, 8'd1);
      drive(1, 1, 0, 1'b0);
      after_edge();
      check("hold_sum_q",   {4'd0, bus_lo.sum_q},     8'd9);
      check("hold_carry_q", {7'd0, bus_lo.carry_q},   8'd1);
      check("hold_valid",   {7'd0, bus_lo.out_valid}, 8'd0);

      // Reset dominates in_valid
      drive(3, 4, 0, 1'b1);
      rst = 1'b1;
      after_edge();
      check("rstv_sum_q",   {4'd0, bus_lo.sum_q},     8'd0);
      check("rstv_carry_q", {7'd0, bus_lo.carry_q},   8'd0);
      check("rstv_valid",   {7'd0, bus_lo.out_valid}, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // Exhaustive legal sweep against decimal arithmetic
      for (int a = 0; a < 10; a++) begin
         for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 2; c++) begin
               comb_check($sformatf("sw_%0d_%0d_%0d", a, b, c), a, b, c,
                          (a + b + c) % 10, (a + b + c) / 10);
            end
         end
      end

      // Two-digit ripple: 47 + 58 = 105
      @(negedge clk);
      bus_hi.nr1 = 4'd4;
      bus_hi.nr2 = 4'd5;
      drive(7, 8, 0, 1'b0);
      check("chain_sum",   {bus_hi.sum, bus_lo.sum}, 8'h05);
      check("chain_carry", {7'd0, bus_hi.carry_out}, 8'd1);

`ifdef SUM_1DIGIT_BCD_DIGIT_CHECK_EN
      drive(12, 3, 0, 1'b1);
      check("err_c_hi", {7'd0, err_lo_c}, 8'd1);
      after_edge();
      check("err_q_hi", {7'd0, err_lo}, 8'd1);
      drive(3, 4, 0, 1'b1);
      check("err_c_lo", {7'd0, err_lo_c}, 8'd0);
      after_edge();
      check("err_q_lo", {7'd0, err_lo}, 8'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
